udp_rx_word_packer: RTL and testbench

//  Receive-side counterpart of the wide UDP send bus. Collects the byte stream leaving the UDP stack
//  (udp_rec_data_valid/udp_rec_rdata/udp_rec_data_length) in the rgmii_clk domain.

---
 rtl/udp_rx_word_packer_if.sv | 26 ++
 rtl/udp_rx_word_packer.sv | 155 +++++++++++++++
 tb/tb_udp_rx_word_packer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_word_packer_if.sv
// Word bus from the receive packer to user logic: valid/ready handshake plus word payload.
interface udp_rx_word_packer_if #(
  parameter int DATA_W = 960
);
  logic              rx_word_valid;
  logic              rx_word_ready;
  logic [DATA_W-1:0] rx_word;
  logic [15:0]       rx_word_len;
  logic              rx_word_last;

  modport master (
    output rx_word_valid,
    output rx_word,
    output rx_word_len,
    output rx_word_last,
    input  rx_word_ready
  );

  modport slave (
    input  rx_word_valid,
    input  rx_word,
    input  rx_word_len,
    input  rx_word_last,
    output rx_word_ready
  );
endinterface

// File: rtl/udp_rx_word_packer.sv
// Packs the UDP receive byte stream into DATA_W-bit words (first byte at the MSB) on a valid/ready bus.
// A word is committed the cycle after it completes; a single holding stage drops and counts words it cannot take.
module udp_rx_word_packer #(
  parameter int DATA_W = 960,
  parameter int CNT_W  = 16
) (
  input  logic                 i_rgmii_clk,
  input  logic                 i_rst,
  input  logic                 i_udp_rec_data_valid,
  input  logic [7:0]           i_udp_rec_rdata,
  input  logic [15:0]          i_udp_rec_data_length,
  udp_rx_word_packer_if.master rx_if,
  output logic                 o_len_err,
  output logic                 o_overflow,
  output logic [CNT_W-1:0]     o_drop_cnt
);

  localparam int              WORD_BYTES = DATA_W / 8;
  localparam int              WC_W       = $clog2(WORD_BYTES + 1);
  localparam logic [WC_W-1:0] WC_FULL    = WC_W'(WORD_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SKIP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_asm, w_asm_nxt;
  logic [WC_W-1:0]   r_word_cnt, w_word_cnt_nxt;
  logic [15:0]       r_dgram_cnt, w_dgram_cnt_nxt;
  logic [15:0]       r_len_lat, w_len_lat_nxt;
  logic              w_store;
  logic [WC_W-1:0]   w_store_idx;
  logic              w_commit;
  logic              w_commit_last;
  logic              w_len_err_nxt;

  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_word;
  logic [15:0]       r_out_len;
  logic              r_out_last;
  logic              r_len_err;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_xfer;

  assign w_xfer = r_out_vld & rx_if.rx_word_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_asm_nxt       = r_asm;
    w_word_cnt_nxt  = r_word_cnt;
    w_dgram_cnt_nxt = r_dgram_cnt;
    w_len_lat_nxt   = r_len_lat;
    w_store         = 1'b0;
    w_store_idx     = '0;
    w_commit        = 1'b0;
    w_commit_last   = 1'b0;
    w_len_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_udp_rec_data_valid) begin
          w_state_nxt     = S_COLLECT;
          w_len_lat_nxt   = i_udp_rec_data_length;
          w_dgram_cnt_nxt = 16'd1;
          w_asm_nxt       = '0;
          w_word_cnt_nxt  = '0;
          w_store         = (i_udp_rec_data_length != 16'd0);
        end
      end
      S_COLLECT: begin
        if (i_udp_rec_data_valid) begin
          if (r_dgram_cnt != 16'hFFFF) w_dgram_cnt_nxt = r_dgram_cnt + 16'd1;
          // Bytes past the declared length are counted for len_err but never stored.
          w_store = (r_dgram_cnt < r_len_lat);
          if (r_word_cnt == WC_FULL) begin
            w_commit       = 1'b1;
            w_commit_last  = !w_store;
            w_asm_nxt      = '0;
            w_word_cnt_nxt = '0;
          end else begin
            w_store_idx = r_word_cnt;
          end
        end else begin
          w_commit        = (r_word_cnt != '0);
          w_commit_last   = 1'b1;
          w_len_err_nxt   = (r_dgram_cnt != r_len_lat);
          w_state_nxt     = S_IDLE;
          w_asm_nxt       = '0;
          w_word_cnt_nxt  = '0;
          w_dgram_cnt_nxt = '0;
        end
      end
      S_SKIP: begin
        if (!i_udp_rec_data_valid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_store) begin
      w_word_cnt_nxt = w_store_idx + WC_W'(1);
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (w_store_idx == WC_W'(k)) w_asm_nxt[DATA_W-1-8*k -: 8] = i_udp_rec_rdata;
      end
    end
  end

  // A reset that lands mid-datagram must not treat the tail as a new datagram.
  always_ff @(posedge i_rgmii_clk) begin
    if (i_rst) begin
      r_state     <= i_udp_rec_data_valid ? S_SKIP : S_IDLE;
      r_asm       <= '0;
      r_word_cnt  <= '0;
      r_dgram_cnt <= '0;
      r_len_lat   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_asm       <= w_asm_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_dgram_cnt <= w_dgram_cnt_nxt;
      r_len_lat   <= w_len_lat_nxt;
    end
  end

  always_ff @(posedge i_rgmii_clk) begin
    if (i_rst) begin
      r_out_vld  <= 1'b0;
      r_out_word <= '0;
      r_out_len  <= '0;
      r_out_last <= 1'b0;
      r_len_err  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_len_err <= w_len_err_nxt;
      if (w_commit && (!r_out_vld || w_xfer)) begin
        r_out_vld  <= 1'b1;
        r_out_word <= r_asm;
        r_out_len  <= 16'(r_word_cnt);
        r_out_last <= w_commit_last;
      end else begin
        if (w_commit) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
        if (w_xfer) r_out_vld <= 1'b0;
      end
    end
  end

  assign rx_if.rx_word_valid = r_out_vld;
  assign rx_if.rx_word       = r_out_word;
  assign rx_if.rx_word_len   = r_out_len;
  assign rx_if.rx_word_last  = r_out_last;
  assign o_len_err           = r_len_err;
  assign o_overflow          = r_overflow;
  assign o_drop_cnt          = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_word_packer.sv
// Directed bench for udp_rx_word_packer: packing, latency, overflow/drop, length errors and mid-datagram reset.
module tb_udp_rx_word_packer;
  localparam int DATA_W = 960;
  localparam int CNT_W  = 16;
  localparam int WB     = DATA_W / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_vld;
  logic [7:0]       in_dat;
  logic [15:0]      in_len;
  logic             len_err;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;

  int checks   = 0;
  int failures = 0;

  udp_rx_word_packer_if #(.DATA_W(DATA_W)) rx_if ();

  udp_rx_word_packer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_rgmii_clk           (clk),
    .i_rst                 (rst),
    .i_udp_rec_data_valid  (in_vld),
    .i_udp_rec_rdata       (in_dat),
    .i_udp_rec_data_length (in_len),
    .rx_if                 (rx_if.master),
    .o_len_err             (len_err),
    .o_overflow            (overflow),
    .o_drop_cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  // Transfer monitor: sampled just after the falling edge, when ready/valid are settled for the next rising edge.
  logic [DATA_W-1:0] cap_word [$];
  int                cap_len  [$];
  logic              cap_last [$];
  int                err_pulses = 0;

  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (rx_if.rx_word_valid && rx_if.rx_word_ready) begin
        cap_word.push_back(rx_if.rx_word);
        cap_len.push_back(int'(rx_if.rx_word_len));
        cap_last.push_back(rx_if.rx_word_last);
      end
      if (len_err) err_pulses++;
    end
  end

  function automatic logic [DATA_W-1:0] mk_word(input int base, input int n);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[DATA_W-1-8*k -: 8] = 8'(base + k);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] cw(input int i);
    return (i < cap_word.size()) ? cap_word[i] : '0;
  endfunction

  function automatic int cl(input int i);
    return (i < cap_len.size()) ? cap_len[i] : -1;
  endfunction

  function automatic logic cla(input int i);
    return (i < cap_last.size()) ? cap_last[i] : 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    int k;
    checks++;
    assert (obs === exp) else begin
      failures++;
      k = 0;
      while (k < WB - 1 && obs[DATA_W-1-8*k -: 8] === exp[DATA_W-1-8*k -: 8]) k++;
      $error("FAIL %s first differing byte %0d observed=%0h expected=%0h",
             tag, k, obs[DATA_W-1-8*k -: 8], exp[DATA_W-1-8*k -: 8]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic [15:0] l);
    in_vld = 1'b1;
    in_dat = d;
    in_len = l;
    @(negedge clk);
  endtask

  // Returns on the falling edge where valid has just been dropped (the first low cycle).
  task automatic send(input int n, input int len, input int base);
    for (int i = 0; i < n; i++) drive_byte(8'(base + i), 16'(len));
    in_vld = 1'b0;
    in_dat = 8'h00;
  endtask

  int nx;
  int e0;

  initial begin
    rst    = 1'b1;
    in_vld = 1'b0;
    in_dat = 8'h00;
    in_len = 16'd0;
    rx_if.rx_word_ready = 1'b0;
    cyc(3);
    chk("rst_valid", rx_if.rx_word_valid, 1'b0);
    chk_word("rst_word", rx_if.rx_word, '0);
    chk("rst_len", rx_if.rx_word_len, 16'd0);
    chk("rst_last", rx_if.rx_word_last, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 16'd0);
    rst = 1'b0;
    rx_if.rx_word_ready = 1'b1;
    cyc(2);

    // 240-byte datagram: two full words, only the second marked last.
    send(240, 240, 0);
    cyc(5);
    chk("t1_words", cap_word.size(), 2);
    chk_word("t1_w0", cw(0), mk_word(0, 120));
    chk("t1_len0", cl(0), 120);
    chk("t1_last0", cla(0), 1'b0);
    chk_word("t1_w1", cw(1), mk_word(8'h78, 120));
    chk("t1_len1", cl(1), 120);
    chk("t1_last1", cla(1), 1'b1);
    chk("t1_len_err", err_pulses, 0);

    // 5-byte datagram: partial word, output valid two cycles after the last byte.
    send(5, 5, 1);
    chk("t2_valid_at_n", rx_if.rx_word_valid, 1'b0);
    cyc(1);
    chk("t2_valid_at_n1", rx_if.rx_word_valid, 1'b1);
    chk("t2_top40", rx_if.rx_word[DATA_W-1 -: 40], 40'h0102030405);
    chk_word("t2_word", rx_if.rx_word, mk_word(1, 5));
    chk("t2_len", rx_if.rx_word_len, 16'd5);
    chk("t2_last", rx_if.rx_word_last, 1'b1);
    cyc(4);
    chk("t2_words", cap_word.size(), 3);
    nx = 3;

    // Consumer stalled for a 360-byte datagram: first word held, the other two dropped.
    rx_if.rx_word_ready = 1'b0;
    send(360, 360, 0);
    cyc(4);
    chk("t3_valid", rx_if.rx_word_valid, 1'b1);
    chk_word("t3_held", rx_if.rx_word, mk_word(0, 120));
    chk("t3_len", rx_if.rx_word_len, 16'd120);
    chk("t3_last", rx_if.rx_word_last, 1'b0);
    chk("t3_drop_cnt", drop_cnt, 16'd2);
    chk("t3_overflow", overflow, 1'b1);
    cyc(3);
    chk_word("t3_stable", rx_if.rx_word, mk_word(0, 120));
    rx_if.rx_word_ready = 1'b1;
    cyc(1);
    chk("t3_valid_after", rx_if.rx_word_valid, 1'b0);
    cyc(3);
    chk("t3_words", cap_word.size(), nx + 1);
    chk_word("t3_xfer_word", cw(nx), mk_word(0, 120));
    chk("t3_xfer_last", cla(nx), 1'b0);
    nx = nx + 1;

    // Ready pulses in the very cycle the next word commits: it replaces the transferring word.
    rx_if.rx_word_ready = 1'b0;
    send(5, 5, 8'hA0);
    cyc(3);
    send(5, 5, 8'hB0);
    rx_if.rx_word_ready = 1'b1;
    cyc(1);
    rx_if.rx_word_ready = 1'b0;
    chk("t4_valid", rx_if.rx_word_valid, 1'b1);
    chk_word("t4_new_word", rx_if.rx_word, mk_word(8'hB0, 5));
    chk("t4_drop_cnt", drop_cnt, 16'd2);
    chk("t4_words", cap_word.size(), nx + 1);
    chk_word("t4_first_xfer", cw(nx), mk_word(8'hA0, 5));
    rx_if.rx_word_ready = 1'b1;
    cyc(3);
    chk_word("t4_second_xfer", cw(nx + 1), mk_word(8'hB0, 5));
    chk("t4_second_last", cla(nx + 1), 1'b1);
    nx = nx + 2;

    // Too many bytes: stored count capped at the length, one len_err pulse.
    e0 = err_pulses;
    send(12, 10, 8'h10);
    cyc(1);
    chk("t5a_len_err_pulse", len_err, 1'b1);
    cyc(1);
    chk("t5a_len_err_drop", len_err, 1'b0);
    cyc(3);
    chk("t5a_words", cap_word.size(), nx + 1);
    chk_word("t5a_word", cw(nx), mk_word(8'h10, 10));
    chk("t5a_len", cl(nx), 10);
    chk("t5a_last", cla(nx), 1'b1);
    chk("t5a_err_count", err_pulses - e0, 1);
    nx = nx + 1;

    // Too few bytes: short word, len_err pulse.
    send(8, 10, 8'h20);
    cyc(5);
    chk_word("t5b_word", cw(nx), mk_word(8'h20, 8));
    chk("t5b_len", cl(nx), 8);
    chk("t5b_last", cla(nx), 1'b1);
    chk("t5b_err_count", err_pulses - e0, 2);
    nx = nx + 1;

    // Exact multiple of the word size: one last word, no empty trailer.
    e0 = err_pulses;
    send(120, 120, 8'h40);
    cyc(5);
    chk("t7_words", cap_word.size(), nx + 1);
    chk_word("t7_word", cw(nx), mk_word(8'h40, 120));
    chk("t7_len", cl(nx), 120);
    chk("t7_last", cla(nx), 1'b1);
    chk("t7_no_err", err_pulses - e0, 0);
    nx = nx + 1;

    // Reset mid-datagram with a word held: everything discarded, tail skipped.
    rx_if.rx_word_ready = 1'b0;
    send(5, 5, 8'h60);
    cyc(3);
    chk("t6_held_before", rx_if.rx_word_valid, 1'b1);
    for (int i = 0; i < 120; i++) begin
      if (i == 50) rst = 1'b1;
      drive_byte(8'(i), 16'd120);
      if (i == 50) begin
        rst = 1'b0;
        chk("t6_rst_valid", rx_if.rx_word_valid, 1'b0);
        chk_word("t6_rst_word", rx_if.rx_word, '0);
        chk("t6_rst_len", rx_if.rx_word_len, 16'd0);
        chk("t6_rst_last", rx_if.rx_word_last, 1'b0);
        chk("t6_rst_overflow", overflow, 1'b0);
        chk("t6_rst_drop_cnt", drop_cnt, 16'd0);
        chk("t6_rst_len_err", len_err, 1'b0);
      end
    end
    in_vld = 1'b0;
    in_dat = 8'h00;
    rx_if.rx_word_ready = 1'b1;
    e0 = err_pulses;
    cyc(5);
    chk("t6_no_word", cap_word.size(), nx);
    chk("t6_no_err", err_pulses - e0, 0);
    chk("t6_valid_idle", rx_if.rx_word_valid, 1'b0);
    send(3, 3, 8'h70);
    cyc(5);
    chk("t6_next_words", cap_word.size(), nx + 1);
    chk_word("t6_next_word", cw(nx), mk_word(8'h70, 3));
    chk("t6_next_len", cl(nx), 3);
    chk("t6_next_last", cla(nx), 1'b1);
    chk("t6_next_no_err", err_pulses - e0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
